// File: rtl/param_loader.sv
// param_loader
// Receives parameter bytes from a host over a valid/ready byte stream and
// shifts them MSB first into a daisy-chain of NEURONS neurons. Each neuron
// takes INPUTS weight bits plus BIAS_BITS bias bits. A load therefore shifts
// NEURONS*(INPUTS+BIAS_BITS) bits, split into ceil(bits/8) bytes. The unused
// low bits of the final byte are dropped.
//
// Optional feature (macro PARAM_LOADER_CHECKSUM_EN):
//   The loader keeps a running XOR of the parameter bytes it accepts. After
//   the last bit has been shifted it accepts one extra checksum byte and
//   raises error when that byte does not match the running XOR. error stays
//   set until the next accepted start or reset. Without the macro, error is
//   tied to 0.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   start      one-cycle load request, honoured only while idle
//   in_data    parameter byte from the host
//   in_valid   in_data is valid
//   in_ready   loader can accept a byte this cycle
//   setup      neuron chain setup enable, high only while bits are shifting
//   param_out  serial bit to the first neuron's param_in
//   busy       a load is in progress
//   done       one-cycle pulse when a load completes
//   error      checksum mismatch flag

module param_loader #(
  parameter int NEURONS   = 4,
  parameter int INPUTS    = 8,
  parameter int BIAS_BITS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       setup,
  output logic       param_out,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int TOTAL_BITS = NEURONS * (INPUTS + BIAS_BITS);
  localparam int CNT_W      = $clog2(TOTAL_BITS + 1);

  // Value of the bit counter while the very last bit of the load is on param_out
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(TOTAL_BITS - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WAIT_BYTE = 3'd1;
  localparam logic [2:0] SHIFT     = 3'd2;
  localparam logic [2:0] DONE      = 3'd4;
`ifdef PARAM_LOADER_CHECKSUM_EN
  localparam logic [2:0] WAIT_CSUM = 3'd3;
  localparam logic [2:0] END_STATE = WAIT_CSUM;
`else
  localparam logic [2:0] END_STATE = DONE;
`endif

  logic [2:0]       state;
  logic [7:0]       shreg;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_pos;

  // Main sequencer. bit_pos counts the bits shifted from the current byte,
  // so a byte ends after 8 bits. The final byte can end early, which is
  // detected from the global bit counter reaching the last bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      shreg   <= 8'h00;
      bit_cnt <= '0;
      bit_pos <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= WAIT_BYTE;
            bit_cnt <= '0;
          end
        end
        WAIT_BYTE: begin
          if (in_valid) begin
            shreg   <= in_data;
            bit_pos <= 3'd0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          shreg   <= {shreg[6:0], 1'b0};
          bit_cnt <= bit_cnt + CNT_W'(1);
          bit_pos <= bit_pos + 3'd1;
          if (bit_cnt == LAST_BIT) begin
            state <= END_STATE;
          end else if (bit_pos == 3'd7) begin
            state <= WAIT_BYTE;
          end
        end
`ifdef PARAM_LOADER_CHECKSUM_EN
        WAIT_CSUM: begin
          if (in_valid) begin
            state <= DONE;
          end
        end
`endif
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef PARAM_LOADER_CHECKSUM_EN
  logic [7:0] csum_acc;
  logic       error_q;

  // The running XOR and the error flag are both cleared by an accepted start.
  // The error flag is written when the checksum byte is taken, so it is
  // already valid in the DONE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csum_acc <= 8'h00;
      error_q  <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        csum_acc <= 8'h00;
        error_q  <= 1'b0;
      end else if (state == WAIT_BYTE && in_valid) begin
        csum_acc <= csum_acc ^ in_data;
      end else if (state == WAIT_CSUM && in_valid) begin
        error_q <= (in_data != csum_acc);
      end
    end
  end

  assign error    = error_q;
  assign in_ready = (state == WAIT_BYTE) || (state == WAIT_CSUM);
`else
  assign error    = 1'b0;
  assign in_ready = (state == WAIT_BYTE);
`endif

  // The chain-facing outputs depend only on registers. This keeps host
  // glitches or a stalled host away from the neuron chain.
  assign setup     = (state == SHIFT);
  assign param_out = (state == SHIFT) && shreg[7];
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_param_loader.sv
// Testbench for param_loader at default parameters.
// A transaction-level reference model predicts the outputs. It tracks load
// progress as counts of bytes taken and bits still owed, and it is compared
// with the DUT on every falling clock edge. Each directed load also checks
// hand-computed literals: the captured serial stream, the setup-cycle count
// and the done-pulse count.
// If PARAM_LOADER_CHECKSUM_EN is defined here as well, the bench also drives
// checksum bytes.

module tb_param_loader;

  localparam int TOTAL_BITS  = 44;
  localparam int TOTAL_BYTES = 6;
`ifdef PARAM_LOADER_CHECKSUM_EN
  localparam int CSUM = 1;
`else
  localparam int CSUM = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready, setup, param_out, busy, done, error;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] load_bytes [TOTAL_BYTES] = '{8'hA5, 8'hFF, 8'h00, 8'h3C, 8'h81, 8'hF0};
  logic [7:0] good_csum;

  // Reference model state
  bit         m_active = 0;
  bit         m_done_now = 0;
  int         m_shift_left = 0;
  int         m_bytes_taken = 0;
  int         m_bits_sent = 0;
  logic [7:0] m_cur_byte = 8'h00;
  logic [7:0] m_xor = 8'h00;
  bit         m_error = 0;

  // Observations gathered by the compare process
  bit                    compare_en = 0;
  int                    setup_cycles = 0;
  int                    done_pulses = 0;
  logic [TOTAL_BITS-1:0] cap_stream = '0;

  always #5 clk = ~clk;

  param_loader dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .setup(setup),
    .param_out(param_out),
    .busy(busy),
    .done(done),
    .error(error)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Load-level model. A start opens a load. Each accepted byte owes
  // min(8, remaining) setup cycles. The load closes with one DONE cycle
  // once all bits are out (or once the checksum byte is taken).
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active = 0; m_done_now = 0; m_shift_left = 0; m_bytes_taken = 0;
      m_bits_sent = 0; m_xor = 8'h00; m_error = 0; m_cur_byte = 8'h00;
    end else if (m_done_now) begin
      m_done_now = 0;
      m_active = 0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1; m_bytes_taken = 0; m_bits_sent = 0; m_xor = 8'h00; m_error = 0;
      end
    end else if (m_shift_left > 0) begin
      m_shift_left--;
      m_bits_sent++;
      if (m_shift_left == 0 && m_bits_sent == TOTAL_BITS && CSUM == 0) m_done_now = 1;
    end else if (in_valid) begin
      if (m_bytes_taken < TOTAL_BYTES) begin
        m_cur_byte = in_data;
        m_shift_left = (TOTAL_BITS - 8 * m_bytes_taken < 8) ? TOTAL_BITS - 8 * m_bytes_taken : 8;
        m_bytes_taken++;
        m_xor ^= in_data;
      end else begin
        m_error = (in_data != m_xor);
        m_done_now = 1;
      end
    end
  end

  // Compare DUT outputs with the model once per cycle, away from the active edge
  always @(negedge clk) begin
    if (compare_en) begin
      logic exp_setup, exp_param;
      int   idx;
      exp_setup = (m_shift_left > 0);
      idx = m_bits_sent - 8 * (m_bytes_taken - 1);
      exp_param = exp_setup ? m_cur_byte[7 - idx] : 1'b0;
      checkOutput("busy", busy, m_active);
      checkOutput("done", done, m_done_now);
      checkOutput("setup", setup, exp_setup);
      checkOutput("in_ready", in_ready, m_active && !m_done_now && !exp_setup);
      checkOutput("param_out", param_out, exp_param);
      checkOutput("error", error, m_error);
      if (setup === 1'b1) begin
        setup_cycles++;
        cap_stream = {cap_stream[TOTAL_BITS-2:0], param_out};
      end
      if (done === 1'b1) done_pulses++;
    end
  end

  // Present one byte and hold it until a transfer happens (bounded)
  task automatic sendByte(input logic [7:0] b);
    int   n;
    logic rdy;
    n = 0;
    rdy = 1'b0;
    in_data = b;
    in_valid = 1'b1;
    while (!rdy && n < 200) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("byte_accepted", rdy, 1'b1);
  endtask

  // Withdraw valid, wait until the loader asks for a byte, then stall
  task automatic stallUntilReady(input int gap);
    int   n;
    logic rdy;
    n = 0;
    rdy = 1'b0;
    in_valid = 1'b0;
    while (!rdy && n < 200) begin
      @(negedge clk);
      rdy = in_ready;
      n++;
    end
    checkOutput("ready_before_stall", rdy, 1'b1);
    repeat (gap) @(posedge clk);
    #1;
  endtask

  // Run one full load: start together with the first byte (so it is not
  // consumed that cycle), optional host stalls, an optional stray start
  // during byte 3, and the checksum byte when the feature is built in.
  task automatic applyStimulus(input int gap, input bit poke_start, input logic [7:0] csum,
                               input logic exp_err);
    int   n;
    logic seen;
    setup_cycles = 0;
    done_pulses = 0;
    cap_stream = '0;
    in_data = load_bytes[0];
    in_valid = 1'b1;
    start = 1'b1;
    @(negedge clk);
    checkOutput("ready_with_start", in_ready, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < TOTAL_BYTES + CSUM; i++) begin
      if (i > 0 && gap > 0) stallUntilReady(gap);
      sendByte((i < TOTAL_BYTES) ? load_bytes[i] : csum);
      if (poke_start && i == 2) begin
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    end
    in_valid = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      seen = done;
      n++;
    end
    checkOutput("done_seen", seen, 1'b1);
    @(negedge clk);
    checkOutput("setup_cycles", setup_cycles, 44);
    checkOutput("done_pulses", done_pulses, 1);
    checkOutput("stream", cap_stream, 44'hA5FF003C81F);
    checkOutput("error_after_done", error, exp_err);
    checkOutput("idle_after_done", busy, 1'b0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    $display("[TB] param_loader bench starting");
    good_csum = 8'h00;
    for (int i = 0; i < TOTAL_BYTES; i++) good_csum ^= load_bytes[i];

    reset = 1'b1;
    compare_en = 1;
    @(negedge clk);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_setup", setup, 1'b0);
    checkOutput("reset_ready", in_ready, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] back-to-back load");
    applyStimulus(0, 0, good_csum, 1'b0);
    $display("[TB] stalled host load");
    applyStimulus(5, 0, good_csum, 1'b0);
    $display("[TB] stray start during byte 3");
    applyStimulus(0, 1, good_csum, 1'b0);

    $display("[TB] reset during byte 2");
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    sendByte(load_bytes[0]);
    sendByte(load_bytes[1]);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("busy_before_reset", busy, 1'b1);
    checkOutput("setup_before_reset", setup, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("async_busy", busy, 1'b0);
    checkOutput("async_setup", setup, 1'b0);
    checkOutput("async_param_out", param_out, 1'b0);
    checkOutput("async_ready", in_ready, 1'b0);
    checkOutput("async_done", done, 1'b0);
    checkOutput("async_error", error, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(0, 0, good_csum, 1'b0);

`ifdef PARAM_LOADER_CHECKSUM_EN
    $display("[TB] checksum mismatch, then clear on next start");
    applyStimulus(0, 0, good_csum ^ 8'h01, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("error_held", error, 1'b1);
    applyStimulus(0, 0, good_csum, 1'b0);
`endif

    repeat (3) @(posedge clk);
    compare_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard time limit so the bench can never hang
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation still running at %0t, required finish", $time);
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "[TB] timeout");
  end

endmodule
